wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Write-back port arbiter and register scoreboard for the 32×32 register file. Shares the file's single write port between three producers: ALU, load unit (MEM) and multiply/divide unit (MDU). Tracks which architectural registers have an in-flight producer so issue logic can stall on RAW hazards. Sits between the execute/memory stages and the register file write inputs.

## Interface
Parameters:
- STARVE_LIMIT, 4: cycles a requester may wait with valid asserted before it is promoted to top priority (range 1–15).

Ports:
- clockIn  in  1  clock; the block updates on the rising edge only.
- reset  in  1  synchronous, active-high reset.
- aluValid / memValid / mduValid  in  1  requester holds a write-back.
- aluAdd / memAdd / mduAdd  in  5  destination register.
- aluData / memData / mduData  in  32  write data.
- aluReady / memReady / mduReady  out  1  grant; the transfer completes when valid && ready at a rising edge.
- reWrite  out  1  write enable to the register file (registered).
- reInAdd  out  5  write address (registered).
- reInData  out  32  write data (registered).
- sbSet  in  1  issue stage marks a destination as pending.
- sbSetAdd  in  5  register being marked.
- sbQAdd1, sbQAdd2  in  5  source registers to check.
- sbBusy1, sbBusy2  out  1  the queried register has a pending producer (combinational).

## Operation
- Handshake: a requester raises valid with stable add/data and holds them until it sees ready. Ready is combinational from the valid inputs and the arbiter state. At most one ready is high per cycle.
- Base priority is fixed: MEM > MDU > ALU.
- Starvation counters:
  - Each requester has a 4-bit wait counter.
  - The counter increments while valid && !ready and saturates at STARVE_LIMIT.
  - It clears on grant or when valid is low.
  - Any requester whose counter equals STARVE_LIMIT is "starved". Starved requesters beat non-starved ones; ties between starved requesters use base priority.
- Write issue: on a granted transfer at edge N, reWrite=1, reInAdd=add and reInData=data hold for the cycle after edge N. With no grant, reWrite=0 and reInAdd/reInData keep their last values.
- Register 0: a transfer to add 0 is granted and completes normally, but reWrite stays 0 for it.
- Scoreboard:
  - One busy bit per register 1–31. Register 0 always reads not-busy.
  - sbSet with add≠0 sets the bit at the edge.
  - A granted transfer clears the bit for its add at the grant edge.
  - If a set and a clear hit the same register in one cycle, set wins.
  - sbBusyN reflects the registered bit vector only. It does not include same-cycle sets or clears.
- Reset: all ready=0 while reset is high; reWrite=0, reInAdd=0, reInData=0; all busy bits and wait counters cleared. A request pending during reset is dropped and must be re-presented after reset deasserts.

## Timing
- Grant latency: 0 cycles for the highest-priority valid requester. A lone valid requester is granted in the same cycle.
- Write latency: reWrite/reInAdd/reInData are valid one cycle after the accepting edge. The register file commits them on the following falling edge of clockIn.
- Scoreboard clear is visible on sbBusyN in the cycle after the grant, together with reWrite.
- Worst-case wait for any continuously valid requester: STARVE_LIMIT + 2 cycles.
- Throughput: one write-back per cycle; no bubbles between back-to-back grants.

## Structure
- Shared package wb_pkg:
  - requester index constants REQ_MEM=0, REQ_MDU=1, REQ_ALU=2 and NUM_REQ=3;
  - register address width 5 and data width 32;
  - default STARVE_LIMIT.
- Sub-module wb_scoreboard:
  - 31-bit busy vector with set/clear ports and two combinational query ports;
  - instantiated once.
- Arbitration, starvation counters and the output registers live in wb_port_arbiter.

## Test plan
- Reset: hold reset for 2 cycles with all valids high → all ready=0 and reWrite=0 throughout; after release, busy=0 for every register.
- Priority: memValid(add 5, 0xAAAA0005), mduValid(add 6) and aluValid(add 7) high together.
  - Edge 1 grants MEM.
  - reWrite=1, reInAdd=5, reInData=0xAAAA0005 next cycle.
  - MDU and ALU are then granted in the following two cycles.
- Starvation: memValid held continuously with a new transfer each cycle, aluValid high, STARVE_LIMIT=4 → ALU is granted on its 5th cycle of waiting; MEM ready=0 in that cycle only.
- Register 0: ALU transfer to add 0 with data 0xFFFFFFFF → aluReady=1 and reWrite stays 0.
- Scoreboard:
  - sbSet add 9 → sbBusy1 with sbQAdd1=9 reads 1 from the next cycle.
  - A MEM grant to add 9 → sbBusy1 reads 0 in the cycle after the grant.
  - sbSet add 9 in the same cycle as a grant to add 9 → still busy.
- Reset mid-transfer: mduValid high and not yet granted, then reset for 1 cycle → no reWrite pulse, wait counters zero; after reset the same request is granted with 0 latency.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the write-back port arbiter: requester indices, widths and
// the fixed-priority picker used by arbitration.
package wb_pkg;

    localparam int unsigned NUM_REQ = 3;
    localparam int unsigned REQ_MEM = 0;
    localparam int unsigned REQ_MDU = 1;
    localparam int unsigned REQ_ALU = 2;

    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned WAIT_W   = 4;

    localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

    typedef logic [ADDR_W-1:0]          reg_addr_t;
    typedef logic [DATA_W-1:0]          reg_data_t;
    typedef logic [WAIT_W-1:0]          wait_cnt_t;
    typedef logic [NUM_REQ-1:0]         req_vec_t;
    typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

    // Lowest index wins, so the index order doubles as the base priority.
    function automatic req_idx_t first_req(input req_vec_t v);
        req_idx_t idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = req_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-producer scoreboard for registers 1-31; register 0 is never busy.
// Queries see only the registered vector, never same-cycle set/clear.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic [ADDR_W-1:0] set_add,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_add,
    input  logic [ADDR_W-1:0] q_add1,
    input  logic [ADDR_W-1:0] q_add2,
    output logic              busy1,
    output logic              busy2
);

    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:1] busy_d;
    logic [NUM_REGS-1:0] busy_vec;

    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (clr && (clr_add == reg_addr_t'(r))) begin
                busy_d[r] = 1'b0;
            end
            // Applied after the clear so a same-cycle set wins.
            if (set && (set_add == reg_addr_t'(r))) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busy_vec = {busy_q, 1'b0};
        busy1    = busy_vec[q_add1];
        busy2    = busy_vec[q_add2];
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between MEM, MDU and ALU with starvation
// promotion, registers the write, and tracks in-flight destinations.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic              clockIn,
    input  logic              reset,

    input  logic              aluValid,
    input  logic [ADDR_W-1:0] aluAdd,
    input  logic [DATA_W-1:0] aluData,
    output logic              aluReady,

    input  logic              memValid,
    input  logic [ADDR_W-1:0] memAdd,
    input  logic [DATA_W-1:0] memData,
    output logic              memReady,

    input  logic              mduValid,
    input  logic [ADDR_W-1:0] mduAdd,
    input  logic [DATA_W-1:0] mduData,
    output logic              mduReady,

    output logic              reWrite,
    output logic [ADDR_W-1:0] reInAdd,
    output logic [DATA_W-1:0] reInData,

    input  logic              sbSet,
    input  logic [ADDR_W-1:0] sbSetAdd,
    input  logic [ADDR_W-1:0] sbQAdd1,
    input  logic [ADDR_W-1:0] sbQAdd2,
    output logic              sbBusy1,
    output logic              sbBusy2
);

    localparam wait_cnt_t Limit = wait_cnt_t'(STARVE_LIMIT);

    req_vec_t  valid_vec;
    req_vec_t  starved;
    req_vec_t  cand;
    req_vec_t  grant;
    req_idx_t  gnt_idx;
    logic      gnt_any;
    reg_addr_t add_arr  [NUM_REQ];
    reg_data_t data_arr [NUM_REQ];
    reg_addr_t sel_add;
    reg_data_t sel_data;
    wait_cnt_t wait_q   [NUM_REQ];
    wait_cnt_t wait_d   [NUM_REQ];

    always_comb begin
        valid_vec          = '0;
        valid_vec[REQ_MEM] = memValid;
        valid_vec[REQ_MDU] = mduValid;
        valid_vec[REQ_ALU] = aluValid;

        add_arr[REQ_MEM]  = memAdd;
        add_arr[REQ_MDU]  = mduAdd;
        add_arr[REQ_ALU]  = aluAdd;
        data_arr[REQ_MEM] = memData;
        data_arr[REQ_MDU] = mduData;
        data_arr[REQ_ALU] = aluData;
    end

    // Starved requesters form the candidate set when any exist; base priority breaks ties.
    always_comb begin
        starved = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = valid_vec[i] && (wait_q[i] == Limit);
        end
        cand    = (|starved) ? starved : valid_vec;
        gnt_any = !reset && (|cand);
        gnt_idx = first_req(cand);

        grant    = '0;
        sel_add  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_any && (gnt_idx == req_idx_t'(i))) begin
                grant[i] = 1'b1;
                sel_add  = add_arr[i];
                sel_data = data_arr[i];
            end
        end
    end

    assign memReady = grant[REQ_MEM];
    assign mduReady = grant[REQ_MDU];
    assign aluReady = grant[REQ_ALU];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            wait_d[i] = wait_q[i];
            if (!valid_vec[i] || grant[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] < Limit) begin
                wait_d[i] = wait_q[i] + wait_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clockIn) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= '0;
            end
            reWrite  <= 1'b0;
            reInAdd  <= '0;
            reInData <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_q[i] <= wait_d[i];
            end
            // Register 0 transfers complete the handshake but never write.
            reWrite <= gnt_any && (sel_add != '0);
            if (gnt_any) begin
                reInAdd  <= sel_add;
                reInData <= sel_data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk     (clockIn),
        .rst     (reset),
        .set     (sbSet),
        .set_add (sbSetAdd),
        .clr     (gnt_any),
        .clr_add (sel_add),
        .q_add1  (sbQAdd1),
        .q_add2  (sbQAdd2),
        .busy1   (sbBusy1),
        .busy2   (sbBusy2)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: expected writes are queued as grants are
// predicted and popped when the register-file write appears.
module tb_wb_port_arbiter;

    localparam int unsigned Limit = 4;

    logic        clockIn;
    logic        reset;
    logic        aluValid, memValid, mduValid;
    logic [4:0]  aluAdd, memAdd, mduAdd;
    logic [31:0] aluData, memData, mduData;
    logic        aluReady, memReady, mduReady;
    logic        reWrite;
    logic [4:0]  reInAdd;
    logic [31:0] reInData;
    logic        sbSet;
    logic [4:0]  sbSetAdd, sbQAdd1, sbQAdd2;
    logic        sbBusy1, sbBusy2;

    int vectors;
    int miscompares;
    logic [36:0] exp_q[$];

    wb_port_arbiter #(
        .STARVE_LIMIT (Limit)
    ) dut (
        .clockIn  (clockIn),
        .reset    (reset),
        .aluValid (aluValid),
        .aluAdd   (aluAdd),
        .aluData  (aluData),
        .aluReady (aluReady),
        .memValid (memValid),
        .memAdd   (memAdd),
        .memData  (memData),
        .memReady (memReady),
        .mduValid (mduValid),
        .mduAdd   (mduAdd),
        .mduData  (mduData),
        .mduReady (mduReady),
        .reWrite  (reWrite),
        .reInAdd  (reInAdd),
        .reInData (reInData),
        .sbSet    (sbSet),
        .sbSetAdd (sbSetAdd),
        .sbQAdd1  (sbQAdd1),
        .sbQAdd2  (sbQAdd2),
        .sbBusy1  (sbBusy1),
        .sbBusy2  (sbBusy2)
    );

    initial begin
        clockIn = 1'b0;
        forever #5 clockIn = ~clockIn;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] rdy();
        return {memReady, mduReady, aluReady};
    endfunction

    // Every write the DUT issues must match the oldest predicted write.
    always @(negedge clockIn) begin
        if (reWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 64'(reWrite), 64'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("wr_add", 64'(reInAdd), 64'(e[36:32]));
                check("wr_data", 64'(reInData), 64'(e[31:0]));
            end
        end
    end

    initial begin
        int          alu_wait;
        int          mem_seq;
        logic        alu_turn;
        logic [2:0]  exp_rdy;

        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        sbSet       = 1'b0;
        sbSetAdd    = '0;
        sbQAdd1     = '0;
        sbQAdd2     = '0;
        memValid = 1'b1; memAdd = 5'd1; memData = 32'h1111_1111;
        mduValid = 1'b1; mduAdd = 5'd2; mduData = 32'h2222_2222;
        aluValid = 1'b1; aluAdd = 5'd3; aluData = 32'h3333_3333;

        // Reset held two cycles with every requester valid.
        repeat (2) begin
            @(negedge clockIn);
            #1;
            check("rst_ready", 64'(rdy()), 64'd0);
            check("rst_rewrite", 64'(reWrite), 64'd0);
            check("rst_readd", 64'(reInAdd), 64'd0);
            check("rst_redata", 64'(reInData), 64'd0);
        end
        reset    = 1'b0;
        memValid = 1'b0;
        mduValid = 1'b0;
        aluValid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sbQAdd1 = 5'(i);
            sbQAdd2 = 5'(31 - i);
            #1;
            check("rst_busy1", 64'(sbBusy1), 64'd0);
            check("rst_busy2", 64'(sbBusy2), 64'd0);
        end

        // Base priority MEM > MDU > ALU.
        @(negedge clockIn);
        memValid = 1'b1; memAdd = 5'd5; memData = 32'hAAAA_0005;
        mduValid = 1'b1; mduAdd = 5'd6; mduData = 32'hBBBB_0006;
        aluValid = 1'b1; aluAdd = 5'd7; aluData = 32'hCCCC_0007;
        exp_q.push_back({5'd5, 32'hAAAA_0005});
        exp_q.push_back({5'd6, 32'hBBBB_0006});
        exp_q.push_back({5'd7, 32'hCCCC_0007});
        #1 check("prio_g_mem", 64'(rdy()), 64'b100);
        @(negedge clockIn);
        memValid = 1'b0;
        #1;
        check("prio_w_en", 64'(reWrite), 64'd1);
        check("prio_w_add", 64'(reInAdd), 64'd5);
        check("prio_w_data", 64'(reInData), 64'hAAAA_0005);
        check("prio_g_mdu", 64'(rdy()), 64'b010);
        @(negedge clockIn);
        mduValid = 1'b0;
        #1 check("prio_g_alu", 64'(rdy()), 64'b001);
        @(negedge clockIn);
        aluValid = 1'b0;
        #1 check("prio_idle", 64'(rdy()), 64'd0);
        @(negedge clockIn);
        #1 check("prio_nowrite", 64'(reWrite), 64'd0);

        // Starvation: MEM streams back-to-back, ALU waits until promoted.
        @(negedge clockIn);
        aluValid = 1'b1; aluAdd = 5'd12; aluData = 32'h5A5A_000C;
        memValid = 1'b1; memAdd = 5'd13; memData = 32'hD000_0000;
        alu_wait = 0;
        mem_seq  = 0;
        for (int c = 0; c < 8; c++) begin
            alu_turn = aluValid && (alu_wait == int'(Limit));
            exp_rdy  = alu_turn ? 3'b001 : 3'b100;
            if (alu_turn) exp_q.push_back({aluAdd, aluData});
            else          exp_q.push_back({memAdd, memData});
            #1 check("starve_ready", 64'(rdy()), 64'(exp_rdy));
            @(negedge clockIn);
            if (alu_turn) begin
                aluValid = 1'b0;
                alu_wait = 0;
            end else begin
                if (aluValid) alu_wait++;
                mem_seq++;
                memAdd  = 5'(13 + mem_seq);
                memData = 32'hD000_0000 + 32'(mem_seq);
            end
        end
        memValid = 1'b0;

        // Register 0: handshake completes, no write.
        @(negedge clockIn);
        aluValid = 1'b1; aluAdd = 5'd0; aluData = 32'hFFFF_FFFF;
        #1 check("r0_ready", 64'(rdy()), 64'b001);
        @(negedge clockIn);
        aluValid = 1'b0;
        #1 check("r0_nowrite", 64'(reWrite), 64'd0);

        // Scoreboard set, clear by grant, and set-wins collision.
        @(negedge clockIn);
        sbSet = 1'b1; sbSetAdd = 5'd9; sbQAdd1 = 5'd9; sbQAdd2 = 5'd0;
        #1 check("sb_set_same_cycle", 64'(sbBusy1), 64'd0);
        @(negedge clockIn);
        sbSet = 1'b0;
        #1 check("sb_set_visible", 64'(sbBusy1), 64'd1);
        @(negedge clockIn);
        memValid = 1'b1; memAdd = 5'd9; memData = 32'h0000_0099;
        exp_q.push_back({5'd9, 32'h0000_0099});
        #1;
        check("sb_clr_ready", 64'(rdy()), 64'b100);
        check("sb_clr_same_cycle", 64'(sbBusy1), 64'd1);
        @(negedge clockIn);
        memValid = 1'b0;
        #1 check("sb_clr_visible", 64'(sbBusy1), 64'd0);
        @(negedge clockIn);
        sbSet = 1'b1; sbSetAdd = 5'd9;
        memValid = 1'b1; memAdd = 5'd9; memData = 32'h0000_1234;
        exp_q.push_back({5'd9, 32'h0000_1234});
        #1 check("sb_coll_ready", 64'(rdy()), 64'b100);
        @(negedge clockIn);
        sbSet = 1'b1; sbSetAdd = 5'd0;
        memValid = 1'b0;
        #1 check("sb_set_wins", 64'(sbBusy1), 64'd1);
        @(negedge clockIn);
        sbSet = 1'b0;
        #1 check("sb_r0_never_busy", 64'(sbBusy2), 64'd0);

        // Reset while MDU is waiting: request dropped, then re-granted at once.
        @(negedge clockIn);
        mduValid = 1'b1; mduAdd = 5'd20; mduData = 32'h2020_2020;
        for (int c = 0; c < 3; c++) begin
            memValid = 1'b1;
            memAdd   = 5'(21 + c);
            memData  = 32'hE000_0000 + 32'(c);
            exp_q.push_back({memAdd, memData});
            #1 check("mid_pre_ready", 64'(rdy()), 64'b100);
            @(negedge clockIn);
        end
        memValid = 1'b0;
        reset    = 1'b1;
        #1 check("mid_rst_ready", 64'(rdy()), 64'd0);
        @(negedge clockIn);
        reset = 1'b0;
        #1;
        check("mid_no_pulse", 64'(reWrite), 64'd0);
        check("mid_regrant", 64'(rdy()), 64'b010);
        exp_q.push_back({mduAdd, mduData});
        @(negedge clockIn);
        mduValid = 1'b0;
        #1 check("mid_write", 64'(reWrite), 64'd1);

        repeat (2) @(negedge clockIn);
        #1 check("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
